// File: rtl/bp_pkg.sv
// Shared types and constants for the fetch-stage next-PC generator.
package bp_pkg;

  localparam logic [31:0] RESET_PC          = 32'hBFC00000;
  localparam logic [31:0] INSTR_BYTES       = 32'd4;
  localparam logic [31:0] DELAY_SLOT_OFFSET = 32'd8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
  } pred_entry_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SLOT    = 2'd1,
    RECOVER = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pred_queue.sv
// FIFO of in-flight predicted-taken branches; clear wins over push/pop,
// and a push is accepted when full if a pop happens in the same cycle.
module pred_queue
  import bp_pkg::*;
#(
  parameter int unsigned QDEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  pred_entry_t push_data,
  input  logic        pop,
  input  logic        clear,
  output pred_entry_t head_c,
  output logic        full,
  output logic        empty
);

  localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(QDEPTH + 1);

  pred_entry_t      mem [QDEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] count;
  logic [OCC_W-1:0] count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head_c  = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + OCC_W'(1);
    end else if (do_pop && !do_push) begin
      count_nxt = count - OCC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      // Pointers wrap naturally because QDEPTH is a power of two.
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      full  <= (count_nxt == OCC_W'(QDEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/next_pc_unit.sv
// Fetch PC generator: follows BTB predictions after the delay slot, checks
// them against ID resolution and recovers with a flush and one bubble.
module next_pc_unit #(
  parameter logic [31:0] RESET_PC = bp_pkg::RESET_PC,
  parameter int unsigned QDEPTH   = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             STALL,
  input  logic             hit_BTB_IN,
  input  logic [31:0]      pred_target_IN,
  input  logic             ID_valid_IN,
  input  logic [31:0]      Instr_PC_IN_ID,
  input  logic             is_Branch_IN_ID,
  input  logic             is_Taken_IN_ID,
  input  logic [31:0]      Alt_PC_IN_ID,
  output logic [31:0]      Instr_PC_OUT_IF,
  output logic             PC_valid_OUT,
  output logic             flush_OUT,
  output logic             queue_full_OUT,
  output logic [CNT_W-1:0] mispredict_count_OUT
);

  import bp_pkg::*;

  fetch_state_t state;
  fetch_state_t state_nxt;
  logic [31:0]  pending;
  logic [31:0]  pending_nxt;
  logic [31:0]  pc_nxt;
  logic         valid_nxt;

  logic         resolve;
  logic         head_match;
  logic         actual_taken;
  logic         mispredict;
  logic [31:0]  redirect_pc;
  logic         push;
  pred_entry_t  push_entry;
  pred_entry_t  head_c;
  logic         q_full;
  logic         q_empty;

  pred_queue #(
    .QDEPTH (QDEPTH)
  ) u_pred_queue (
    .clk       (CLK),
    .rst       (RESET),
    .push      (push),
    .push_data (push_entry),
    .pop       (head_match),
    .clear     (mispredict),
    .head_c    (head_c),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign queue_full_OUT = q_full;
  assign push_entry     = '{pc: Instr_PC_OUT_IF, target: pred_target_IN};

  // Compare the ID-stage outcome against the oldest in-flight prediction.
  always_comb begin
    resolve      = ID_valid_IN & ~STALL;
    head_match   = resolve & ~q_empty & (head_c.pc == Instr_PC_IN_ID);
    actual_taken = resolve & is_Branch_IN_ID & is_Taken_IN_ID;
    mispredict   = resolve & ((head_match != actual_taken)
                 | (head_match & actual_taken & (head_c.target != Alt_PC_IN_ID))
                 | (head_match & ~is_Branch_IN_ID));
    redirect_pc  = actual_taken ? Alt_PC_IN_ID : Instr_PC_IN_ID + DELAY_SLOT_OFFSET;
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = Instr_PC_OUT_IF;
    valid_nxt   = PC_valid_OUT;
    pending_nxt = pending;
    push        = 1'b0;
    if (!STALL) begin
      case (state)
        RUN: begin
          if (!PC_valid_OUT) begin
            // Held on a full queue: release once an entry is freed.
            if (!q_full || head_match) valid_nxt = 1'b1;
          end else if (hit_BTB_IN) begin
            if (!q_full || head_match) begin
              push        = 1'b1;
              pending_nxt = pred_target_IN;
              pc_nxt      = Instr_PC_OUT_IF + INSTR_BYTES;
              state_nxt   = SLOT;
            end else begin
              valid_nxt = 1'b0;
            end
          end else begin
            pc_nxt = Instr_PC_OUT_IF + INSTR_BYTES;
          end
        end
        SLOT: begin
          pc_nxt    = pending;
          state_nxt = RUN;
        end
        RECOVER: begin
          valid_nxt = 1'b1;
          state_nxt = RUN;
        end
        default: begin
          state_nxt = RUN;
        end
      endcase
      if (mispredict) begin
        push      = 1'b0;
        pc_nxt    = redirect_pc;
        valid_nxt = 1'b0;
        state_nxt = RECOVER;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state                <= RUN;
      Instr_PC_OUT_IF      <= RESET_PC;
      PC_valid_OUT         <= 1'b1;
      pending              <= '0;
      flush_OUT            <= 1'b0;
      mispredict_count_OUT <= '0;
    end else begin
      state           <= state_nxt;
      Instr_PC_OUT_IF <= pc_nxt;
      PC_valid_OUT    <= valid_nxt;
      pending         <= pending_nxt;
      flush_OUT       <= mispredict;
      if (mispredict && !(&mispredict_count_OUT)) begin
        mispredict_count_OUT <= mispredict_count_OUT + CNT_W'(1);
      end
    end
  end

endmodule
